// File: rtl/fsm_timed.sv
// Three-state control FSM (S0/S1/S2) with per-state dwell counter, S1 fixed duration and S2 timeout.
// Optional feature macro FSM_STATS_EN: when defined, s1_visits counts entries into S1; otherwise it is tied to 0.
module fsm_timed #(
    parameter int CNT_W      = 8,
    parameter int S1_CYCLES  = 4,
    parameter int S2_TIMEOUT = 16,
    parameter int RST_STATE  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in1,
    input  logic             in2,
    output logic             out1,
    output logic             out2,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] dwell,
    output logic             timeout,
    output logic [CNT_W-1:0] s1_visits
);

    typedef enum logic [1:0] {
        ST_S0  = 2'd0,
        ST_S1  = 2'd1,
        ST_S2  = 2'd2,
        ST_BAD = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] S1_LAST   = CNT_W'(S1_CYCLES - 1);
    localparam logic [CNT_W-1:0] S2_LAST   = CNT_W'(S2_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] DWELL_MAX = {CNT_W{1'b1}};
    localparam state_t           RST_ENC   = state_t'(2'(RST_STATE));

    if (S1_CYCLES < 1 || longint'(S1_CYCLES) > (longint'(1) << CNT_W)) begin : g_bad_s1
        $error("fsm_timed: S1_CYCLES=%0d out of range 1..2**CNT_W", S1_CYCLES);
    end
    if (S2_TIMEOUT < 2 || longint'(S2_TIMEOUT) > (longint'(1) << CNT_W)) begin : g_bad_s2
        $error("fsm_timed: S2_TIMEOUT=%0d out of range 2..2**CNT_W", S2_TIMEOUT);
    end
    if (RST_STATE < 0 || RST_STATE > 2) begin : g_bad_rst
        $error("fsm_timed: RST_STATE=%0d out of range 0..2", RST_STATE);
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic             timeout_q, timeout_d;

    always_comb begin
        state_d   = state_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_S0: if (in1) state_d = ST_S1;
            ST_S1: if (dwell_q == S1_LAST) state_d = ST_S2;
            ST_S2: begin
                // Input-driven exits take priority, so a timeout is flagged only when nothing else fires.
                if (in1 && in2) begin
                    state_d = ST_S1;
                end else if (!in1) begin
                    state_d = ST_S0;
                end else if (dwell_q == S2_LAST) begin
                    state_d   = ST_S0;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = ST_S0;
        endcase

        if (state_d != state_q) begin
            dwell_d = '0;
        end else if (dwell_q == DWELL_MAX) begin
            dwell_d = dwell_q;
        end else begin
            dwell_d = dwell_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RST_ENC;
            dwell_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dwell_q   <= dwell_d;
            timeout_q <= timeout_d;
        end
    end

    assign out1    = (state_q == ST_S0) || (state_q == ST_S2);
    assign out2    = (state_q == ST_S1);
    assign state_o = state_q;
    assign dwell   = dwell_q;
    assign timeout = timeout_q;

`ifdef FSM_STATS_EN
    logic [CNT_W-1:0] s1_visits_q, s1_visits_d;

    always_comb begin
        s1_visits_d = s1_visits_q;
        if (state_d == ST_S1 && state_q != ST_S1) begin
            s1_visits_d = s1_visits_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_visits_q <= '0;
        end else begin
            s1_visits_q <= s1_visits_d;
        end
    end

    assign s1_visits = s1_visits_q;
`else
    assign s1_visits = '0;
`endif

endmodule

// File: tb/tb_fsm_timed.sv
// Scoreboard bench for fsm_timed: a behavioural model pushes the expected post-edge
// outputs for each driven cycle; they are popped and compared one cycle later.
module tb_fsm_timed;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst, in1, in2;
    logic             out1, out2, timeout;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] dwell, s1_visits;

    fsm_timed #(.CNT_W(CNT_W), .S1_CYCLES(4), .S2_TIMEOUT(16), .RST_STATE(1)) dut (
        .clk(clk), .rst(rst), .in1(in1), .in2(in2),
        .out1(out1), .out2(out2), .state_o(state_o), .dwell(dwell),
        .timeout(timeout), .s1_visits(s1_visits)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]       st;
        logic [CNT_W-1:0] dw;
        logic             to;
        logic             o1;
        logic             o2;
        logic [CNT_W-1:0] vis;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

`ifdef FSM_STATS_EN
    localparam logic [CNT_W-1:0] VIS3 = 8'd3;
`else
    localparam logic [CNT_W-1:0] VIS3 = 8'd0;
`endif

    // Reference model state
    logic [1:0]       m_st;
    logic [CNT_W-1:0] m_dw, m_vis;
    logic             m_to;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model(input logic i1, input logic i2, input logic r);
        logic [1:0] ns;
        logic       nto;
        if (r) begin
            m_st = 2'd1; m_dw = '0; m_to = 1'b0; m_vis = '0;
            return;
        end
        nto = 1'b0;
        case (m_st)
            2'd0:    ns = i1 ? 2'd1 : 2'd0;
            2'd1:    ns = (m_dw == 8'd3) ? 2'd2 : 2'd1;
            2'd2:    if (i1 && i2) ns = 2'd1;
                     else if (!i1) ns = 2'd0;
                     else if (m_dw == 8'd15) begin ns = 2'd0; nto = 1'b1; end
                     else ns = 2'd2;
            default: ns = 2'd0;
        endcase
`ifdef FSM_STATS_EN
        if (ns == 2'd1 && m_st != 2'd1) m_vis = m_vis + 8'd1;
`endif
        if (ns != m_st) m_dw = '0;
        else if (m_dw != 8'hFF) m_dw = m_dw + 8'd1;
        m_st = ns;
        m_to = nto;
    endtask

    task automatic step(input logic i1, input logic i2, input logic r);
        exp_t e;
        @(negedge clk);
        in1 = i1; in2 = i2; rst = r;
        model(i1, i2, r);
        e.st = m_st; e.dw = m_dw; e.to = m_to;
        e.o1 = (m_st == 2'd0) || (m_st == 2'd2);
        e.o2 = (m_st == 2'd1);
        e.vis = m_vis;
        sb.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        e = sb.pop_front();
        chk("state_o", 32'(state_o), 32'(e.st));
        chk("dwell", 32'(dwell), 32'(e.dw));
        chk("timeout", 32'(timeout), 32'(e.to));
        chk("out1", 32'(out1), 32'(e.o1));
        chk("out2", 32'(out2), 32'(e.o2));
        chk("s1_visits", 32'(s1_visits), 32'(e.vis));
        $display("cyc=%0d rst=%b in1=%b in2=%b state=%0d dwell=%0d to=%b vis=%0d",
                 cyc, r, i1, i2, state_o, dwell, timeout, s1_visits);
    endtask

    // Drive in1=1,in2=0 until the model sits in S2 with the requested dwell.
    task automatic goto_s2(input logic [CNT_W-1:0] k);
        for (int i = 0; i < 100 && !(m_st == 2'd2 && m_dw == k); i++) step(1'b1, 1'b0, 1'b0);
        chk("reach_s2_state", 32'(state_o), 32'd2);
        chk("reach_s2_dwell", 32'(dwell), 32'(k));
    endtask

    initial begin
        rst = 1'b1; in1 = 1'b0; in2 = 1'b0;
        m_st = 2'd0; m_dw = '0; m_to = 1'b0; m_vis = '0;

        // 1: reset release, S1 x4 -> S2 x1 -> S0
        step(0, 0, 1); step(0, 0, 1);
        chk("rst_state", 32'(state_o), 32'd1);
        chk("rst_dwell", 32'(dwell), 32'd0);
        for (int i = 0; i < 6; i++) step(0, 0, 0);
        chk("t1_s0", 32'(state_o), 32'd0);

        // 2: one-cycle in1 pulse from S0
        step(1, 0, 0);
        chk("t2_s1", 32'(state_o), 32'd1);
        for (int i = 0; i < 5; i++) step(0, 0, 0);

        // 3: hold in S2 until timeout
        goto_s2(8'd15);
        step(1, 0, 0);
        chk("t3_timeout", 32'(timeout), 32'd1);
        chk("t3_state", 32'(state_o), 32'd0);
        step(0, 0, 0);
        chk("t3_pulse_end", 32'(timeout), 32'd0);

        // 4: normal exits on the timeout cycle
        goto_s2(8'd15);
        step(0, 0, 0);
        chk("t4a_state", 32'(state_o), 32'd0);
        chk("t4a_timeout", 32'(timeout), 32'd0);
        goto_s2(8'd15);
        step(1, 1, 0);
        chk("t4b_state", 32'(state_o), 32'd1);
        chk("t4b_timeout", 32'(timeout), 32'd0);
        for (int i = 0; i < 6; i++) step(0, 0, 0);

        // 5: reset mid-S2
        goto_s2(8'd7);
        step(1, 0, 1);
        chk("t5_state", 32'(state_o), 32'd1);
        chk("t5_visits", 32'(s1_visits), 32'd0);

        // 6: three S0->S1 passes after reset
        for (int i = 0; i < 6; i++) step(0, 0, 0);
        for (int p = 0; p < 3; p++) begin
            step(1, 0, 0);
            for (int i = 0; i < 6; i++) step(0, 0, 0);
        end
        chk("t6_visits", 32'(s1_visits), 32'(VIS3));

        // Dwell saturation while idling in S0
        for (int i = 0; i < 300; i++) step(0, 0, 0);
        chk("sat_dwell", 32'(dwell), 32'hFF);

        // Random traffic with occasional reset
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 60) == 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
